// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG entropy packer.
//   MRK_PREFIX / EOI / RST0 : marker byte values
//   state_e                 : packer FSM state encoding
//   len_w_ok()              : true when a LEN_W-bit field can hold MAX_LEN
package jpeg_pkg;

    localparam logic [7:0] MRK_PREFIX = 8'hFF;
    localparam logic [7:0] EOI        = 8'hD9;
    localparam logic [7:0] RST0       = 8'hD0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PAD,
        ST_MARK0,
        ST_MARK1
    } state_e;

    function automatic bit len_w_ok(input int len_w, input int max_len);
        return (64'(1) << len_w) > 64'(max_len);
    endfunction

endpackage

// File: rtl/jpeg_byte_stuffer.sv
// Output byte register with 0x00 stuffing after data 0xFF.
//   in_valid_i/in_ready_o/in_data_i/in_marker_i : byte source handshake;
//                                                 marker bytes are never stuffed
//   out_valid_o/out_ready_i/out_data_o           : byte sink handshake
// The register advances only when empty or drained, so out_data_o is held
// while out_valid_o && !out_ready_i.
module jpeg_byte_stuffer
    import jpeg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid_i,
    input  logic [7:0] in_data_i,
    input  logic       in_marker_i,
    output logic       in_ready_o,
    output logic       out_valid_o,
    output logic [7:0] out_data_o,
    input  logic       out_ready_i
);

    logic       vld_q, vld_d;
    logic       stuff_q, stuff_d;
    logic [7:0] data_q, data_d;
    logic       adv;

    assign adv        = !vld_q || out_ready_i;
    // A pending stuff byte owns the next slot, so the source is held off.
    assign in_ready_o = adv && !stuff_q;

    always_comb begin
        vld_d   = vld_q;
        data_d  = data_q;
        stuff_d = stuff_q;
        if (adv) begin
            if (stuff_q) begin
                vld_d   = 1'b1;
                data_d  = 8'h00;
                stuff_d = 1'b0;
            end else if (in_valid_i) begin
                vld_d   = 1'b1;
                data_d  = in_data_i;
                stuff_d = !in_marker_i && (in_data_i == MRK_PREFIX);
            end else begin
                vld_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= 1'b0;
            stuff_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            vld_q   <= vld_d;
            stuff_q <= stuff_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = vld_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/jpeg_entropy_packer.sv
// Merges per-component entropy segments into a JPEG byte stream.
//   frame_start / frame_end        : frame control pulses
//   ch_valid/ch_ready/ch_len/
//   ch_data/ch_last                : per-channel segment handshake, served in
//                                    channel order 0..NCH-1 per MCU
//   o_valid/o_ready/o_data         : stuffed byte stream to the sink
//   dc_reset                       : pulse telling encoders to clear DC predictors
//   err                            : sticky protocol error
// Bits are appended at the LSB end of acc_q; the oldest bit sits at acc_cnt-1.
module jpeg_entropy_packer
    import jpeg_pkg::*;
#(
    parameter int NCH          = 3,
    parameter int MAX_LEN      = 32,
    parameter int LEN_W        = 6,
    parameter int ACC_W        = 64,
    parameter int RST_INTERVAL = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic                   frame_end,
    input  logic [NCH-1:0]         ch_valid,
    output logic [NCH-1:0]         ch_ready,
    input  logic [NCH*LEN_W-1:0]   ch_len,
    input  logic [NCH*MAX_LEN-1:0] ch_data,
    input  logic [NCH-1:0]         ch_last,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [7:0]             o_data,
    output logic                   dc_reset,
    output logic                   err
);

    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CNT_W-1:0] EIGHT = CNT_W'(8);

    if (!len_w_ok(LEN_W, MAX_LEN) || ACC_W < 2 * MAX_LEN) begin : g_bad_params
        $error("jpeg_entropy_packer: LEN_W or ACC_W too small for MAX_LEN");
    end

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CH_W-1:0]    cur_ch_q, cur_ch_d;
    logic [15:0]        mcu_q, mcu_d;
    logic [2:0]         rst_idx_q, rst_idx_d;
    logic               fe_pend_q, fe_pend_d;
    logic               eoi_q, eoi_d;
    logic               dcr_q, dcr_d;
    logic               err_q, err_d;

    logic               sel_valid, sel_last, room, accept, emit;
    logic [LEN_W-1:0]   sel_len, len_c;
    logic [MAX_LEN-1:0] sel_data;
    logic [ACC_W-1:0]   seg;
    logic [7:0]         top_byte, pad_byte, s_data;
    logic               s_valid, s_ready, s_marker;

    assign sel_valid = ch_valid[cur_ch_q];
    assign sel_last  = ch_last[cur_ch_q];
    assign sel_len   = ch_len[int'(cur_ch_q) * LEN_W +: LEN_W];
    assign sel_data  = ch_data[int'(cur_ch_q) * MAX_LEN +: MAX_LEN];

    // Room for a worst-case segment; depends on registered state only.
    assign room   = (int'(cnt_q) + MAX_LEN) <= ACC_W;
    assign accept = (state_q == ST_DATA) && room && sel_valid;

    for (genvar i = 0; i < NCH; i++) begin : g_ready
        assign ch_ready[i] = (state_q == ST_DATA) && (int'(cur_ch_q) == i) && room;
    end

    assign len_c    = (int'(sel_len) > MAX_LEN) ? LEN_W'(MAX_LEN) : sel_len;
    assign seg      = ACC_W'(sel_data) & ((ACC_W'(1) << len_c) - ACC_W'(1));
    assign top_byte = 8'(acc_q >> (cnt_q - EIGHT));
    // Remainder left-justified, vacated low bits filled with 1s.
    assign pad_byte = 8'(acc_q << (EIGHT - cnt_q)) | (8'hFF >> cnt_q);

    always_comb begin
        s_valid  = 1'b0;
        s_data   = top_byte;
        s_marker = 1'b0;
        case (state_q)
            ST_DATA:  s_valid = (cnt_q >= EIGHT);
            ST_PAD: begin
                if (cnt_q >= EIGHT) begin
                    s_valid = 1'b1;
                end else if (cnt_q != '0) begin
                    s_valid = 1'b1;
                    s_data  = pad_byte;
                end
            end
            ST_MARK0: begin
                s_valid  = 1'b1;
                s_data   = MRK_PREFIX;
                s_marker = 1'b1;
            end
            ST_MARK1: begin
                s_valid  = 1'b1;
                s_data   = eoi_q ? EOI : (RST0 + 8'(rst_idx_q));
                s_marker = 1'b1;
            end
            default: ;
        endcase
    end

    assign emit = s_valid && s_ready;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        cur_ch_d  = cur_ch_q;
        mcu_d     = mcu_q;
        rst_idx_d = rst_idx_q;
        fe_pend_d = fe_pend_q;
        eoi_d     = eoi_q;
        dcr_d     = 1'b0;
        err_d     = err_q;

        if (frame_end && state_q != ST_IDLE) fe_pend_d = 1'b1;
        if (frame_start && state_q != ST_IDLE) err_d = 1'b1;

        // A pad byte consumes the whole sub-byte remainder.
        if (emit && (state_q == ST_DATA || state_q == ST_PAD))
            cnt_d = (cnt_q >= EIGHT) ? (cnt_q - EIGHT) : '0;

        if (accept) begin
            acc_d = (acc_q << len_c) | seg;
            cnt_d = cnt_d + CNT_W'(len_c);
            if (int'(sel_len) > MAX_LEN) err_d = 1'b1;
            if (sel_last) begin
                if (int'(cur_ch_q) == NCH - 1) begin
                    cur_ch_d = '0;
                    // EOI outranks a due restart marker.
                    if (fe_pend_q || frame_end) begin
                        state_d   = ST_PAD;
                        eoi_d     = 1'b1;
                        fe_pend_d = 1'b0;
                    end else if (RST_INTERVAL != 0 && int'(mcu_q) + 1 == RST_INTERVAL) begin
                        state_d = ST_PAD;
                        eoi_d   = 1'b0;
                        mcu_d   = '0;
                    end else begin
                        mcu_d = mcu_q + 1'b1;
                    end
                end else begin
                    cur_ch_d = cur_ch_q + 1'b1;
                end
            end
        end

        case (state_q)
            ST_IDLE: if (frame_start) begin
                state_d   = ST_DATA;
                dcr_d     = 1'b1;
                rst_idx_d = '0;
                mcu_d     = '0;
                cur_ch_d  = '0;
                fe_pend_d = 1'b0;
                cnt_d     = '0;
            end
            ST_PAD:   if (cnt_q < EIGHT && (cnt_q == '0 || emit)) state_d = ST_MARK0;
            ST_MARK0: if (emit) state_d = ST_MARK1;
            ST_MARK1: if (emit) begin
                if (eoi_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d   = ST_DATA;
                    rst_idx_d = rst_idx_q + 1'b1;
                    dcr_d     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            cur_ch_q  <= '0;
            mcu_q     <= '0;
            rst_idx_q <= '0;
            fe_pend_q <= 1'b0;
            eoi_q     <= 1'b0;
            dcr_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            cur_ch_q  <= cur_ch_d;
            mcu_q     <= mcu_d;
            rst_idx_q <= rst_idx_d;
            fe_pend_q <= fe_pend_d;
            eoi_q     <= eoi_d;
            dcr_q     <= dcr_d;
            err_q     <= err_d;
        end
    end

    assign dc_reset = dcr_q;
    assign err      = err_q;

    jpeg_byte_stuffer u_stuffer (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (s_valid),
        .in_data_i   (s_data),
        .in_marker_i (s_marker),
        .in_ready_o  (s_ready),
        .out_valid_o (o_valid),
        .out_data_o  (o_data),
        .out_ready_i (o_ready)
    );

endmodule
